ln_norm_sched: RTL and testbench

- Sequencer for the LayerNorm normalize stage (64-lane, 11-stage pipeline plus output register, 12 enabled cycles from trigger to result).
- Accepts one row job from the statistics stage: mean and inv_sqrt, latched on start.
- Per job, it:
  - walks the raw-data and gamma/beta buffers beat by beat;
  - drives the stage's valid trigger, address tag, enable and held mean/inv_sqrt;
  - checks returned tags and signals row completion.

---
 rtl/ln_pkg.sv | 16 +
 rtl/ln_en_delay.sv | 26 ++
 rtl/ln_norm_sched.sv | 126 ++++++++++++
 tb/tb_ln_norm_sched.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ln_pkg.sv
// Shared types and constants for the LayerNorm normalize-stage sequencer.
package ln_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    DRAIN,
    DONE
  } ln_state_e;

  localparam int unsigned LN_LANES    = 64;
  localparam int unsigned LN_TAG_W    = 6;
  localparam int unsigned LN_NORM_LAT = 12;

endpackage

// File: rtl/ln_en_delay.sv
// Enabled shift register, W bits wide and D stages deep (D >= 1).
module ln_en_delay #(
  parameter int unsigned W = 1,
  parameter int unsigned D = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] sr [D];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < D; i++) sr[i] <= '0;
    end else if (en) begin
      sr[0] <= din;
      for (int unsigned i = 1; i < D; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[D-1];

endmodule

// File: rtl/ln_norm_sched.sv
// Sequencer for the LayerNorm normalize stage: issues beat reads, drives the
// stage trigger/tag, checks returned tags and signals row completion.
module ln_norm_sched
  import ln_pkg::*;
#(
  parameter int unsigned BEATS    = 12,
  parameter int unsigned ADDR_W   = LN_TAG_W,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned PIPE_LAT = LN_NORM_LAT,
  parameter int unsigned WD_SLACK = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic signed [31:0]       i_mean,
  input  logic signed [16:0]       i_inv_sqrt,
  input  logic                     i_out_ready,
  output logic                     o_busy,
  output logic                     o_rd_en,
  output logic [ADDR_W-1:0]        o_rd_addr,
  output logic                     o_stage_en,
  output logic                     o_valid_trigger,
  output logic [ADDR_W-1:0]        o_tag,
  output logic signed [31:0]       o_mean,
  output logic signed [16:0]       o_inv_sqrt,
  input  logic                     i_res_valid,
  input  logic [ADDR_W-1:0]        i_res_addr,
  output logic                     o_done,
  output logic                     o_err
);

  localparam logic [ADDR_W:0] LAST_BEAT = (ADDR_W+1)'(BEATS - 1);
  localparam logic [5:0]      WD_LIMIT  = 6'(RD_LAT + PIPE_LAT + WD_SLACK);
  localparam int unsigned     MASK_W    = $clog2(PIPE_LAT + 2);

  ln_state_e         state_q, state_d;
  logic              en, accept, issuing, counting, res_hit, ret_last, timeout;
  logic [ADDR_W:0]   issue_cnt, ret_cnt;
  logic [5:0]        wd_cnt;
  logic [MASK_W-1:0] mask_cnt;
  logic              trig_q;
  logic [ADDR_W-1:0] tag_q;

  assign en       = i_out_ready;
  assign accept   = (state_q == IDLE) && i_start;
  assign issuing  = en && (state_q == ISSUE);
  assign counting = (state_q == ISSUE) || (state_q == DRAIN);
  assign res_hit  = en && i_res_valid;
  assign ret_last = res_hit && (ret_cnt == LAST_BEAT);
  assign timeout  = (state_q == DRAIN) && !ret_last && (wd_cnt >= WD_LIMIT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = LOAD;
      LOAD:    state_d = ISSUE;
      ISSUE:   if (issue_cnt == LAST_BEAT) state_d = DRAIN;
      DRAIN:   if (ret_last || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Start acceptance bypasses the enable; everything else advances only with en.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      issue_cnt  <= '0;
      ret_cnt    <= '0;
      wd_cnt     <= '0;
      o_mean     <= '0;
      o_inv_sqrt <= '0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_done <= en && (state_d == DONE);
      if (accept) begin
        state_q    <= LOAD;
        issue_cnt  <= '0;
        ret_cnt    <= '0;
        wd_cnt     <= '0;
        o_mean     <= i_mean;
        o_inv_sqrt <= i_inv_sqrt;
        o_err      <= 1'b0;
      end else begin
        if (en) begin
          state_q <= state_d;
          if (issuing) issue_cnt <= issue_cnt + 1'b1;
          if (res_hit && counting) ret_cnt <= ret_cnt + 1'b1;
          if ((state_q == DRAIN) && (wd_cnt != '1)) wd_cnt <= wd_cnt + 1'b1;
        end
        if (res_hit && counting && (i_res_addr != ret_cnt[ADDR_W-1:0])) o_err <= 1'b1;
        if (res_hit && !counting && (mask_cnt == '0)) o_err <= 1'b1;
        if (en && timeout) o_err <= 1'b1;
      end
    end
  end

  // Results still in flight when reset hit must not be flagged as spurious.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mask_cnt <= MASK_W'(PIPE_LAT);
    end else if (en && (mask_cnt != '0)) begin
      mask_cnt <= mask_cnt - 1'b1;
    end
  end

  ln_en_delay #(
    .W (ADDR_W + 1),
    .D (RD_LAT)
  ) u_trig_dly (
    .clk  (i_clk),
    .rst  (i_rst),
    .en   (en),
    .din  ({o_rd_en, o_rd_addr}),
    .dout ({trig_q, tag_q})
  );

  assign o_busy          = (state_q == LOAD) || (state_q == ISSUE) || (state_q == DRAIN);
  assign o_rd_en         = issuing;
  assign o_rd_addr       = issuing ? issue_cnt[ADDR_W-1:0] : '0;
  assign o_stage_en      = i_out_ready;
  assign o_valid_trigger = trig_q && en;
  assign o_tag           = tag_q;

endmodule

// File: tb/tb_ln_norm_sched.sv
// Directed bench for ln_norm_sched: three instances (BEATS 12, 1, 64), each fed
// by a 12-deep enabled stage model; instance 0 supports tag swap / beat drop.
module tb_ln_norm_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ready = 1'b1;
  logic mclr = 1'b1;
  logic signed [31:0] mean_in = '0;
  logic signed [16:0] inv_in = '0;

  logic start_v [3];
  logic busy_v [3], rd_en_v [3], stage_en_v [3], trig_v [3], res_valid_v [3], done_v [3], err_v [3];
  logic [5:0] rd_addr_v [3], tag_v [3], res_addr_v [3];
  logic signed [31:0] mean_o [3];
  logic signed [16:0] inv_o [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ln_norm_sched #(.BEATS(12)) u_b12 (
    .i_clk(clk), .i_rst(rst), .i_start(start_v[0]), .i_mean(mean_in), .i_inv_sqrt(inv_in),
    .i_out_ready(ready), .o_busy(busy_v[0]), .o_rd_en(rd_en_v[0]), .o_rd_addr(rd_addr_v[0]),
    .o_stage_en(stage_en_v[0]), .o_valid_trigger(trig_v[0]), .o_tag(tag_v[0]),
    .o_mean(mean_o[0]), .o_inv_sqrt(inv_o[0]), .i_res_valid(res_valid_v[0]),
    .i_res_addr(res_addr_v[0]), .o_done(done_v[0]), .o_err(err_v[0]));

  ln_norm_sched #(.BEATS(1)) u_b1 (
    .i_clk(clk), .i_rst(rst), .i_start(start_v[1]), .i_mean(mean_in), .i_inv_sqrt(inv_in),
    .i_out_ready(ready), .o_busy(busy_v[1]), .o_rd_en(rd_en_v[1]), .o_rd_addr(rd_addr_v[1]),
    .o_stage_en(stage_en_v[1]), .o_valid_trigger(trig_v[1]), .o_tag(tag_v[1]),
    .o_mean(mean_o[1]), .o_inv_sqrt(inv_o[1]), .i_res_valid(res_valid_v[1]),
    .i_res_addr(res_addr_v[1]), .o_done(done_v[1]), .o_err(err_v[1]));

  ln_norm_sched #(.BEATS(64)) u_b64 (
    .i_clk(clk), .i_rst(rst), .i_start(start_v[2]), .i_mean(mean_in), .i_inv_sqrt(inv_in),
    .i_out_ready(ready), .o_busy(busy_v[2]), .o_rd_en(rd_en_v[2]), .o_rd_addr(rd_addr_v[2]),
    .o_stage_en(stage_en_v[2]), .o_valid_trigger(trig_v[2]), .o_tag(tag_v[2]),
    .o_mean(mean_o[2]), .o_inv_sqrt(inv_o[2]), .i_res_valid(res_valid_v[2]),
    .i_res_addr(res_addr_v[2]), .o_done(done_v[2]), .o_err(err_v[2]));

  // Stage model: 12 enabled cycles from sampled trigger to result
  logic pv [3][12];
  logic [5:0] pt [3][12];
  logic swap34 = 1'b0;
  int drop_tag = -1;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (mclr) begin
        for (int s = 0; s < 12; s++) begin
          pv[k][s] <= 1'b0;
          pt[k][s] <= '0;
        end
      end else if (ready) begin
        for (int s = 11; s > 0; s--) begin
          pv[k][s] <= pv[k][s-1];
          pt[k][s] <= pt[k][s-1];
        end
        pv[k][0] <= trig_v[k] && !(k == 0 && int'(tag_v[k]) == drop_tag);
        pt[k][0] <= (k == 0 && swap34 && tag_v[k] == 6'd3) ? 6'd4 :
                    (k == 0 && swap34 && tag_v[k] == 6'd4) ? 6'd3 : tag_v[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      res_valid_v[k] = pv[k][11];
      res_addr_v[k]  = pt[k][11];
    end
  end

  // Event logs, cycle numbers relative to the start edge
  int rd_c[$], rd_a[$], tr_c[$], tr_t[$], rs_c[$], done_c[$];
  int done_cnt [3], trig_cnt [3], done_rel [3];
  logic [5:0] last_tag [3];
  logic err_at_done [3];
  int hold_bad = 0;
  logic signed [31:0] exp_mean = '0;
  logic signed [16:0] exp_inv = '0;

  always @(negedge clk) begin
    if (rd_en_v[0]) begin rd_c.push_back(cyc - t0); rd_a.push_back(int'(rd_addr_v[0])); end
    if (trig_v[0]) begin tr_c.push_back(cyc - t0); tr_t.push_back(int'(tag_v[0])); end
    if (ready && res_valid_v[0]) rs_c.push_back(cyc - t0);
    if (done_v[0]) done_c.push_back(cyc - t0);
    for (int k = 0; k < 3; k++) begin
      if (trig_v[k]) begin trig_cnt[k]++; last_tag[k] = tag_v[k]; end
      if (done_v[k]) begin done_cnt[k]++; err_at_done[k] = err_v[k]; done_rel[k] = cyc - t0; end
    end
    if ((busy_v[0] || done_v[0]) && (mean_o[0] !== exp_mean || inv_o[0] !== exp_inv)) hold_bad++;
  end

  task automatic clear_logs();
    rd_c.delete(); rd_a.delete(); tr_c.delete(); tr_t.delete(); rs_c.delete(); done_c.delete();
    for (int k = 0; k < 3; k++) begin
      done_cnt[k] = 0; trig_cnt[k] = 0; done_rel[k] = -1; last_tag[k] = '0; err_at_done[k] = 1'b0;
    end
    hold_bad = 0;
  endtask

  task automatic start_job(input logic [2:0] which, input logic signed [31:0] m, input logic signed [16:0] v);
    @(negedge clk);
    mean_in = m;
    inv_in = v;
    for (int k = 0; k < 3; k++) start_v[k] = which[k];
    @(posedge clk);
    #1;
    t0 = cyc;
    for (int k = 0; k < 3; k++) start_v[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt[k] >= 1) break;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy_v[0], rd_en_v[0], trig_v[0], done_v[0], err_v[0]} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=00000", {busy_v[0], rd_en_v[0], trig_v[0], done_v[0], err_v[0]});
    end
    checks++;
    if (mean_o[0] !== 32'sd0 || inv_o[0] !== 17'sd0) begin
      errors++;
      $display("FAIL reset_data got mean=%h inv=%h exp 0/0", mean_o[0], inv_o[0]);
    end
    checks++;
    if (rd_addr_v[0] !== 6'd0 || tag_v[0] !== 6'd0) begin
      errors++;
      $display("FAIL reset_addr got rd=%h tag=%h exp 0/0", rd_addr_v[0], tag_v[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    mclr = 1'b0;
    repeat (14) @(posedge clk);
  endtask

  task automatic check_nominal(input string nm, input int exp_done);
    int bad;
    checks++;
    if (!(done_c.size() == 1 && done_c[0] == exp_done)) begin
      errors++;
      $display("FAIL %s_done got n=%0d at=%0d exp n=1 at=%0d", nm, done_c.size(),
               (done_c.size() > 0) ? done_c[0] : -1, exp_done);
    end
    bad = 0;
    foreach (rd_a[i]) if (rd_a[i] != i) bad++;
    checks++;
    if (bad != 0 || rd_a.size() != 12) begin
      errors++;
      $display("FAIL %s_rd_addr got n=%0d bad=%0d exp n=12 bad=0", nm, rd_a.size(), bad);
    end
    bad = 0;
    foreach (tr_t[i]) if (tr_t[i] != i) bad++;
    checks++;
    if (bad != 0 || tr_t.size() != 12) begin
      errors++;
      $display("FAIL %s_tags got n=%0d bad=%0d exp n=12 bad=0", nm, tr_t.size(), bad);
    end
    checks++;
    if (err_at_done[0] !== 1'b0 || hold_bad != 0) begin
      errors++;
      $display("FAIL %s_err_hold got err=%b hold_bad=%0d exp 0/0", nm, err_at_done[0], hold_bad);
    end
  endtask

  task automatic test_nominal();
    clear_logs();
    exp_mean = 32'sh000001F4; exp_inv = 17'sh00400;
    start_job(3'b001, exp_mean, exp_inv);
    wait_done(0, 60);
    check_nominal("nominal", 26);
    checks++;
    if (!(rd_c.size() == 12 && rd_c[0] == 1 && rd_c[11] == 12)) begin
      errors++;
      $display("FAIL nominal_rd_cycles got n=%0d first=%0d last=%0d exp 12/1/12", rd_c.size(),
               (rd_c.size() > 0) ? rd_c[0] : -1, (rd_c.size() > 11) ? rd_c[11] : -1);
    end
    checks++;
    if (!(tr_c.size() == 12 && tr_c[0] == 2 && tr_c[11] == 13)) begin
      errors++;
      $display("FAIL nominal_trig_cycles got n=%0d first=%0d exp 12/2..13", tr_c.size(),
               (tr_c.size() > 0) ? tr_c[0] : -1);
    end
    checks++;
    if (!(rs_c.size() == 12 && rs_c[0] == 14 && rs_c[11] == 25)) begin
      errors++;
      $display("FAIL nominal_res_cycles got n=%0d first=%0d exp 12/14..25", rs_c.size(),
               (rs_c.size() > 0) ? rs_c[0] : -1);
    end
    checks++;
    if (busy_v[0] !== 1'b0 || mean_o[0] !== 32'sh000001F4 || inv_o[0] !== 17'sh00400) begin
      errors++;
      $display("FAIL nominal_after got busy=%b mean=%h inv=%h exp 0/000001f4/00400", busy_v[0], mean_o[0], inv_o[0]);
    end
  endtask

  task automatic test_stall();
    int bad;
    clear_logs();
    start_job(3'b001, exp_mean, exp_inv);
    repeat (5) @(posedge clk);
    #1 ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 ready = 1'b1;
    wait_done(0, 60);
    check_nominal("stall", 29);
    bad = 0;
    foreach (rd_c[i]) if (rd_c[i] != ((i < 4) ? 1 + i : 4 + i)) bad++;
    foreach (tr_c[i]) if (tr_c[i] != ((i < 3) ? 2 + i : 5 + i)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_timing got bad=%0d exp 0", bad);
    end
  endtask

  task automatic test_tag_error();
    clear_logs();
    swap34 = 1'b1;
    start_job(3'b001, exp_mean, exp_inv);
    wait_done(0, 60);
    swap34 = 1'b0;
    checks++;
    if (!(done_c.size() == 1 && done_c[0] == 26 && rs_c.size() == 12)) begin
      errors++;
      $display("FAIL tagerr_done got n=%0d res=%0d exp n=1 at 26 res=12", done_c.size(), rs_c.size());
    end
    checks++;
    if (err_at_done[0] !== 1'b1 || err_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL tagerr_err got at_done=%b now=%b exp 1/1", err_at_done[0], err_v[0]);
    end
    clear_logs();
    start_job(3'b001, exp_mean, exp_inv);
    checks++;
    if (err_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL tagerr_clear got err=%b exp 0", err_v[0]);
    end
    wait_done(0, 60);
    check_nominal("tagerr_next", 26);
  endtask

  task automatic test_timeout();
    clear_logs();
    drop_tag = 7;
    start_job(3'b001, exp_mean, exp_inv);
    wait_done(0, 80);
    drop_tag = -1;
    checks++;
    if (!(done_c.size() == 1 && done_c[0] >= 30 && done_c[0] <= 32)) begin
      errors++;
      $display("FAIL timeout_done got n=%0d at=%0d exp n=1 at 30..32", done_c.size(),
               (done_c.size() > 0) ? done_c[0] : -1);
    end
    checks++;
    if (err_at_done[0] !== 1'b1 || rs_c.size() != 11) begin
      errors++;
      $display("FAIL timeout_err got err=%b res=%0d exp 1/11", err_at_done[0], rs_c.size());
    end
    @(posedge clk); #1;
    checks++;
    if (busy_v[0] !== 1'b0 || rd_en_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle got busy=%b rd=%b done=%b exp 000", busy_v[0], rd_en_v[0], done_v[0]);
    end
  endtask

  task automatic test_reset_mid_job();
    clear_logs();
    start_job(3'b001, exp_mean, exp_inv);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy_v[0], rd_en_v[0], trig_v[0], done_v[0], err_v[0]} !== 5'b0 || mean_o[0] !== 32'sd0 || inv_o[0] !== 17'sd0) begin
      errors++;
      $display("FAIL midrst_outputs got ctrl=%b mean=%h inv=%h exp 0", {busy_v[0], rd_en_v[0], trig_v[0], done_v[0], err_v[0]}, mean_o[0], inv_o[0]);
    end
    rst = 1'b0;
    exp_mean = '0; exp_inv = '0;
    repeat (20) @(posedge clk); #1;
    checks++;
    if (err_v[0] !== 1'b0 || done_cnt[0] != 0) begin
      errors++;
      $display("FAIL midrst_stale got err=%b done=%0d exp 0/0", err_v[0], done_cnt[0]);
    end
    clear_logs();
    exp_mean = 32'sh000001F4; exp_inv = 17'sh00400;
    start_job(3'b001, exp_mean, exp_inv);
    wait_done(0, 60);
    check_nominal("midrst_fresh", 26);
  endtask

  task automatic test_busy_start();
    clear_logs();
    exp_mean = 32'sh12345678; exp_inv = 17'sh0ABCD;
    start_job(3'b001, exp_mean, exp_inv);
    repeat (5) @(posedge clk);
    #1;
    mean_in = 32'sh7EADBEEF; inv_in = 17'sh01111; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    wait_done(0, 60);
    check_nominal("busystart", 26);
    repeat (30) @(posedge clk); #1;
    checks++;
    if (done_cnt[0] != 1 || busy_v[0] !== 1'b0 || mean_o[0] !== 32'sh12345678) begin
      errors++;
      $display("FAIL busystart_ignored got done=%0d busy=%b mean=%h exp 1/0/12345678", done_cnt[0], busy_v[0], mean_o[0]);
    end
  endtask

  task automatic test_boundary();
    clear_logs();
    start_job(3'b110, 32'sh00000010, 17'sh00200);
    wait_done(1, 40);
    wait_done(2, 120);
    checks++;
    if (done_cnt[1] != 1 || done_rel[1] != 15 || trig_cnt[1] != 1 || last_tag[1] !== 6'h00 || err_at_done[1] !== 1'b0) begin
      errors++;
      $display("FAIL beats1 got done=%0d at=%0d trig=%0d tag=%h err=%b exp 1/15/1/00/0",
               done_cnt[1], done_rel[1], trig_cnt[1], last_tag[1], err_at_done[1]);
    end
    checks++;
    if (done_cnt[2] != 1 || done_rel[2] != 78 || trig_cnt[2] != 64 || last_tag[2] !== 6'h3F || err_at_done[2] !== 1'b0) begin
      errors++;
      $display("FAIL beats64 got done=%0d at=%0d trig=%0d tag=%h err=%b exp 1/78/64/3f/0",
               done_cnt[2], done_rel[2], trig_cnt[2], last_tag[2], err_at_done[2]);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) start_v[k] = 1'b0;
    clear_logs();
    test_reset();
    test_nominal();
    test_stall();
    test_tag_error();
    test_timeout();
    test_reset_mid_job();
    test_busy_start();
    test_boundary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got time=%0t exp finish earlier", $time);
    $fatal(1);
  end

endmodule
